// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared widths, FSM state encoding and iteration count for the
//           sequential signed divider.
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_DW = 16;
  localparam int DIV_VW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // One quotient bit per iteration, so the count equals the dividend width.
  function automatic int div_iters(input int dw);
    return dw;
  endfunction

  localparam int DIV_ITERS = div_iters(DIV_DW);

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step : one restoring-division iteration on magnitudes (shift in the next
//            dividend bit, trial subtract, restore on borrow, emit quotient bit).
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_step #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic [VW:0]   acc_i,
  input  logic [DW-1:0] dq_i,
  input  logic [VW-1:0] dvs_i,
  output logic [VW:0]   acc_o,
  output logic [DW-1:0] dq_o,
  output logic          qbit_o
);

  logic [VW:0]   w_shift;
  logic [VW+1:0] w_diff;

  assign w_shift = {acc_i[VW-1:0], dq_i[DW-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, dvs_i};

  // A set top bit of acc_i means the shifted value already exceeds any divisor.
  assign qbit_o = acc_i[VW] | ~w_diff[VW+1];
  assign acc_o  = qbit_o ? w_diff[VW:0] : w_shift;
  assign dq_o   = {dq_i[DW-2:0], qbit_o};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider : multi-cycle signed (truncating) divider, DW-bit dividend by
//               VW-bit divisor, with divide-by-zero and overflow flags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          dbz,
  output logic          ovf
);

  localparam logic [DW-1:0] C_LAST_CNT = DW'(div_iters(DW) - 1);
  localparam logic [DW-1:0] C_DVD_MIN  = {1'b1, {(DW-1){1'b0}}};

  div_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [VW:0]   acc_q, acc_d;
  logic [DW-1:0] dq_q, dq_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          negq_q, negq_d;
  logic          negr_q, negr_d;
  logic [VW-1:0] rres_q, rres_d;
  logic          dbzp_q, dbzp_d;
  logic          ovfp_q, ovfp_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;
  logic          ovf_q, ovf_d;

  logic [DW-1:0] w_dvd_mag;
  logic [VW-1:0] w_dvs_mag;
  logic [VW:0]   w_acc_nxt;
  logic [DW-1:0] w_dq_nxt;
  logic          w_qbit;

  // The most negative value maps to its unsigned magnitude (e.g. 16'h8000).
  assign w_dvd_mag = dividend[DW-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[VW-1]  ? -divisor  : divisor;

  div_step #(.DW(DW), .VW(VW)) u_step (
    .acc_i  (acc_q),
    .dq_i   (dq_q),
    .dvs_i  (dvs_q),
    .acc_o  (w_acc_nxt),
    .dq_o   (w_dq_nxt),
    .qbit_o (w_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    rres_d  = rres_q;
    dbzp_d  = dbzp_q;
    ovfp_d  = ovfp_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d  = 1'b0;
          ovf_d  = 1'b0;
          cnt_d  = '0;
          acc_d  = '0;
          dq_d   = w_dvd_mag;
          dvs_d  = w_dvs_mag;
          negq_d = dividend[DW-1] ^ divisor[VW-1];
          negr_d = dividend[DW-1];
          dbzp_d = 1'b0;
          ovfp_d = (dividend == C_DVD_MIN) && (divisor == '1);
          if (divisor == '0) begin
            dbzp_d  = 1'b1;
            ovfp_d  = 1'b0;
            dq_d    = '1;
            rres_d  = dividend[VW-1:0];
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = w_acc_nxt;
        dq_d  = w_dq_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST_CNT) state_d = FIX;
      end
      FIX: begin
        dq_d    = negq_q ? -dq_q : dq_q;
        rres_d  = negr_q ? -acc_q[VW-1:0] : acc_q[VW-1:0];
        state_d = DONE;
      end
      DONE: begin
        quo_d   = dq_q;
        rem_d   = rres_q;
        dbz_d   = dbzp_q;
        ovf_d   = ovfp_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      rres_q  <= '0;
      dbzp_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      rres_q  <= rres_d;
      dbzp_q  <= dbzp_d;
      ovfp_q  <= ovfp_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DW, default 16, meaning dividend and quotient width in bits.
REQ-002 SHALL have parameter VW, default 8, meaning divisor and remainder width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a division.
REQ-006 SHALL have port dividend, input, DW bits: signed two's-complement dividend.
REQ-007 SHALL have port divisor, input, VW bits: signed two's-complement divisor.
REQ-008 SHALL have port quotient, output, DW bits: signed quotient, registered.
REQ-009 SHALL have port remainder, output, VW bits: signed remainder, registered.
REQ-010 SHALL have port busy, output, 1 bit: a division is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking valid results.
REQ-012 SHALL have port dbz, output, 1 bit: divide-by-zero flag for the last result.
REQ-013 SHALL have port ovf, output, 1 bit: quotient-overflow flag for the last result.

Function
REQ-014 SHALL accept start only when busy=0; operands are captured on the accepting edge (edge 0), and later input changes have no effect.
REQ-015 SHALL ignore start while busy=1, with no state change and no queuing.
REQ-016 SHALL use FSM states IDLE, CALC, FIX, DONE.
- IDLE->CALC on an accepted start with divisor!=0.
- IDLE->DONE on an accepted start with divisor==0.
- CALC->FIX after DW iterations.
- FIX->DONE.
- DONE->IDLE unconditionally.
REQ-017 SHALL perform CALC as restoring division on magnitudes, one quotient bit per cycle, MSB first, using a (VW+1)-bit partial remainder and a DW-bit iteration counter.
REQ-018 SHALL apply signs in FIX.
- Quotient negated when the dividend and divisor signs differ.
- Remainder takes the dividend's sign (truncating division); magnitude < |divisor|.
REQ-019 SHALL keep busy=1 from edge 0 through edge DW+1 for a nonzero divisor; after edge DW+2, busy=0 and done=1 for exactly one cycle (latency DW+2=18 cycles at default widths).
REQ-020 SHALL, for divisor==0, set done=1, dbz=1, quotient=all ones and remainder=dividend[VW-1:0] after edge 1, then return to IDLE.
REQ-021 SHALL, for dividend=-2^(DW-1) and divisor=-1, set ovf=1 and quotient=-2^(DW-1) (wrapped), with remainder 0.
REQ-022 SHALL hold quotient, remainder, dbz and ovf stable from done until the next done.
- dbz and ovf clear on the next accepted start.
REQ-023 SHALL accept a start asserted in the done cycle on the following edge, because the FSM is already in IDLE by then.

Reset
REQ-024 SHALL, with rst=1 at a rising edge, force FSM=IDLE, quotient=0, remainder=0, busy=0, done=0, dbz=0, ovf=0, and counter=0.
REQ-025 SHALL give rst priority over start.
- Reset mid-operation aborts the division.
- No done is produced for the aborted division.
- The next start after reset release is accepted normally.

Structure
REQ-026 SHALL place the following in shared package div_pkg: DW/VW defaults, the FSM state enum, and the iteration-count constant.
REQ-027 SHALL implement one iteration (shift, trial subtract, restore, quotient bit) in a combinational sub-module div_step, instantiated once in seq_divider.
REQ-028 SHALL contain no multipliers and no latches; all outputs SHALL be driven from flops.

Verification
REQ-029 SHALL cover: dividend=100, divisor=7 -> after 18 cycles done=1, quotient=14, remainder=2, dbz=0, ovf=0.
REQ-030 SHALL cover: -100/7 -> quotient=16'hFFF2 (-14), remainder=8'hFE (-2); and 100/-7 -> quotient=-14, remainder=2.
REQ-031 SHALL cover: -32768/-1 -> ovf=1, quotient=16'h8000, remainder=0; and -32768/1 -> ovf=0, quotient=16'h8000.
REQ-032 SHALL cover: 1234/0 -> done=1 two cycles after start, dbz=1, quotient=16'hFFFF, remainder=8'hD2.
REQ-033 SHALL cover: start 100/7, re-pulse start with 50/5 at cycle 5 -> single done at cycle 18 with quotient=14; a start in the done cycle is accepted.
REQ-034 SHALL cover: rst at cycle 9 of a division -> all outputs 0 next cycle, no done; a following 100/7 completes correctly.
